poly_add_ctrl: RTL and testbench

POLY_ADD_CTRL -- requirements
Module: poly_add_ctrl

---
 rtl/poly_add_ctrl_if.sv | 32 +++
 rtl/poly_add_ctrl.sv | 139 +++++++++++++
 tb/tb_poly_add_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// poly_add_ctrl_if
// Operand/result RAM bus between the modular vector adder and its coefficient
// memories.
//   rd_en, rd_addr   : read strobe/address to operand RAMs A and B
//   rd_a, rd_b       : operand data, valid one cycle after rd_en
//   wr_en, wr_addr   : result RAM write strobe/address
//   wr_data          : result coefficient
// master = controller side, slave = RAM side.
// -----------------------------------------------------------------------------
interface poly_add_ctrl_if #(
   parameter int DW = 12,
   parameter int AW = 8
);
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_a;
   logic [DW-1:0] rd_b;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_a, rd_b
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_a, rd_b
   );
endinterface

// File: rtl/poly_add_ctrl.sv
// -----------------------------------------------------------------------------
// poly_add_ctrl
// Streams N coefficient pairs out of RAMs A and B, adds them modulo p and
// writes the results to the result RAM, one coefficient per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : launch one vector operation (sampled only when idle)
//   len        : coefficient count N, 0..2^AW, captured with start
//   neg_p      : 2^DW - p, captured with start
//   busy, done : busy outside IDLE; done pulses for one cycle at the end
//   ram        : read/write RAM bus (master side)
// Pipeline: read issue -> RAM data valid -> registered write, so the write for
// index k lands two cycles after its read strobe.
// DW defaults to 12 (the ntt datawidth); override at instantiation if needed.
// -----------------------------------------------------------------------------
module poly_add_ctrl #(
   parameter int DW = 12,
   parameter int AW = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [AW:0]           len,
   input  logic [DW-1:0]         neg_p,
   output logic                  busy,
   output logic                  done,
   poly_add_ctrl_if.master       ram
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t        state_q,   state_d;
   logic [AW:0]   len_q,     len_d;
   logic [AW:0]   idx_q,     idx_d;     // AW+1 bits so N=2^AW does not wrap
   logic [DW-1:0] neg_p_q,   neg_p_d;
   logic          rd_en_q,   rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          rvld_q,    rvld_d;    // read data valid this cycle
   logic [AW-1:0] raddr_q,   raddr_d;   // address matching the valid data
   logic          wr_en_q,   wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic [DW:0]   s1, s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         neg_p_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rvld_q    <= 1'b0;
         raddr_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         neg_p_q   <= neg_p_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         rvld_q    <= rvld_d;
         raddr_q   <= raddr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      // a+b-p is taken when a+b+(2^DW-p) carries out of DW bits, i.e. a+b >= p
      s1 = {1'b0, ram.rd_a} + {1'b0, ram.rd_b};
      s2 = s1 + {1'b0, neg_p_q};

      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      neg_p_d   = neg_p_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      rvld_d    = rd_en_q;
      raddr_d   = rd_addr_q;
      wr_en_d   = rvld_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (rvld_q) begin
         wr_addr_d = raddr_q;
         wr_data_d = s2[DW] ? s2[DW-1:0] : s1[DW-1:0];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = len;
               neg_p_d = neg_p;
               if (len != '0) begin
                  // index 0 is issued on the cycle right after the start edge
                  rd_en_d   = 1'b1;
                  rd_addr_d = '0;
                  idx_d     = (AW+1)'(1);
                  state_d   = RUN;
               end else begin
                  idx_d   = '0;
                  state_d = FIN;
               end
            end
         end
         RUN: begin
            if (idx_q == len_q) begin
               state_d = DRAIN;
            end else begin
               rd_en_d   = 1'b1;
               rd_addr_d = idx_q[AW-1:0];
               idx_d     = idx_q + (AW+1)'(1);
            end
         end
         DRAIN: begin
            // final write is on the bus and nothing is left behind it
            if (wr_en_q && !rvld_q) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN);
   assign ram.rd_en   = rd_en_q;
   assign ram.rd_addr = rd_addr_q;
   assign ram.wr_en   = wr_en_q;
   assign ram.wr_addr = wr_addr_q;
   assign ram.wr_data = wr_data_q;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_poly_add_ctrl
// Directed bench for poly_add_ctrl: a synchronous RAM model feeds operands, a
// negedge monitor collects per-run statistics (cycle numbers relative to the
// start edge, counts, captured results) and each test task checks them
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_poly_add_ctrl;
   localparam int DW = 12;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   len = '0;
   logic [DW-1:0] neg_p = '0;
   logic          busy, done;

   poly_add_ctrl_if #(.DW(DW), .AW(AW)) bus ();

   poly_add_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .len   (len),
      .neg_p (neg_p),
      .busy  (busy),
      .done  (done),
      .ram   (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem_a [256];
   logic [DW-1:0] mem_b [256];
   logic [DW-1:0] res   [256];

   // synchronous-read operand RAMs
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_a <= mem_a[bus.rd_addr];
         bus.rd_b <= mem_b[bus.rd_addr];
      end
   end

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int nvec = 0;
   int nmis = 0;
   int t0 = 0;
   int launch_id = 0;
   int seen_id = 0;
   int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0;
   int done_cyc = -1, first_rd = -1, last_rd = -1, last_wr = -1;
   int ord_err = 0;

   // cycle 1 is the cycle right after the start edge
   always @(negedge clk) begin
      int cyc;
      cyc = edge_cnt - t0;
      if (seen_id != launch_id) begin
         seen_id  = launch_id;
         rd_cnt   = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0;
         done_cyc = -1; first_rd = -1; last_rd = -1; last_wr = -1;
         ord_err  = 0;
         for (int i = 0; i < 256; i++) res[i] = 'x;
      end
      if (bus.rd_en === 1'b1) begin
         if (first_rd < 0) first_rd = cyc;
         if (int'(bus.rd_addr) != (rd_cnt % 256)) ord_err++;
         rd_cnt++;
         last_rd = cyc;
      end
      if (bus.wr_en === 1'b1) begin
         if (int'(bus.wr_addr) != (wr_cnt % 256)) ord_err++;
         res[bus.wr_addr] = bus.wr_data;
         wr_cnt++;
         last_wr = cyc;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // caller must be away from the rising edge; returns 1ns into cycle 1
   task automatic launch(input int n, input int np);
      start = 1'b1;
      len   = (AW+1)'(n);
      neg_p = DW'(np);
      @(posedge clk);
      #1;
      start = 1'b0;
      t0 = edge_cnt - 1;
      launch_id++;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!(seen_id == launch_id && done_cnt != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] got [8];
      logic [31:0] exp [8];
      string       nm  [8];
      rst = 1'b1;
      start = 1'b1;          // reset wins over a simultaneous start
      len = 9'd4;
      neg_p = 12'd767;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      got = '{32'(bus.rd_en), 32'(bus.wr_en), 32'(done), 32'(busy),
              32'(bus.rd_addr), 32'(bus.wr_addr), 32'(bus.wr_data), 32'(dut.state_q)};
      exp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      nm  = '{"rd_en", "wr_en", "done", "busy", "rd_addr", "wr_addr", "wr_data", "state"};
      for (int k = 0; k < 8; k++) begin
         nvec++;
         if (got[k] !== exp[k]) begin
            nmis++;
            $display("FAIL reset.%s: got %0h want %0h", nm[k], got[k], exp[k]);
         end
      end
   endtask

   task automatic test_basic(input string tag);
      int          got [9];
      int          exp [9];
      string       nm  [9];
      logic [DW-1:0] ev [4];
      mem_a[0] = 12'd1; mem_a[1] = 12'd3000; mem_a[2] = 12'd3328; mem_a[3] = 12'd0;
      mem_b[0] = 12'd2; mem_b[1] = 12'd1000; mem_b[2] = 12'd1;    mem_b[3] = 12'd0;
      ev = '{12'd3, 12'd671, 12'd0, 12'd0};
      @(negedge clk);
      launch(4, 767);
      wait_done(40);
      got = '{wr_cnt, rd_cnt, first_rd, last_rd, last_wr, done_cyc, done_cnt, busy_cnt, ord_err};
      exp = '{4, 4, 1, 4, 6, 7, 1, 7, 0};
      nm  = '{"wr_cnt", "rd_cnt", "first_rd", "last_rd", "last_wr", "done_cyc",
              "done_cnt", "busy_cycles", "addr_order"};
      for (int k = 0; k < 9; k++) begin
         nvec++;
         if (got[k] !== exp[k]) begin
            nmis++;
            $display("FAIL %s.%s: got %0d want %0d", tag, nm[k], got[k], exp[k]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (res[k] !== ev[k]) begin
            nmis++;
            $display("FAIL %s.data[%0d]: got %0d want %0d", tag, k, res[k], ev[k]);
         end
      end
   endtask

   task automatic test_len0();
      int    got [6];
      int    exp [6];
      string nm  [6];
      @(negedge clk);
      launch(0, 767);
      wait_done(20);
      got = '{rd_cnt, wr_cnt, done_cyc, done_cnt, busy_cnt, int'(busy)};
      exp = '{0, 0, 1, 1, 1, 0};
      nm  = '{"rd_cnt", "wr_cnt", "done_cyc", "done_cnt", "busy_cycles", "busy_after"};
      for (int k = 0; k < 6; k++) begin
         nvec++;
         if (got[k] !== exp[k]) begin
            nmis++;
            $display("FAIL len0.%s: got %0d want %0d", nm[k], got[k], exp[k]);
         end
      end
   endtask

   task automatic test_full();
      int            got [9];
      int            exp [9];
      string         nm  [9];
      logic [DW-1:0] e;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = DW'(i);
         mem_b[i] = 12'd3328;
      end
      @(negedge clk);
      launch(256, 767);
      wait_done(400);
      got = '{wr_cnt, rd_cnt, first_rd, last_rd, last_wr, done_cyc, done_cnt, busy_cnt, ord_err};
      exp = '{256, 256, 1, 256, 258, 259, 1, 259, 0};
      nm  = '{"wr_cnt", "rd_cnt", "first_rd", "last_rd", "last_wr", "done_cyc",
              "done_cnt", "busy_cycles", "addr_order"};
      for (int k = 0; k < 9; k++) begin
         nvec++;
         if (got[k] !== exp[k]) begin
            nmis++;
            $display("FAIL full.%s: got %0d want %0d", nm[k], got[k], exp[k]);
         end
      end
      for (int i = 0; i < 256; i++) begin
         e = (i == 0) ? 12'd3328 : DW'(i - 1);
         nvec++;
         if (res[i] !== e) begin
            nmis++;
            $display("FAIL full.data[%0d]: got %0d want %0d", i, res[i], e);
         end
      end
   endtask

   task automatic test_ignored_start();
      int            got [6];
      int            exp [6];
      string         nm  [6];
      logic [DW-1:0] ev [4];
      mem_a[0] = 12'd1; mem_a[1] = 12'd3000; mem_a[2] = 12'd3328; mem_a[3] = 12'd0;
      mem_b[0] = 12'd2; mem_b[1] = 12'd1000; mem_b[2] = 12'd1;    mem_b[3] = 12'd0;
      ev = '{12'd3, 12'd671, 12'd0, 12'd0};
      @(negedge clk);
      launch(4, 767);
      repeat (2) @(negedge clk);          // cycle 2
      start = 1'b1; len = 9'd2; neg_p = 12'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);          // cycle 7 (FIN)
      start = 1'b1; len = 9'd2; neg_p = 12'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);                     // cycle 8, first IDLE cycle
      got = '{wr_cnt, rd_cnt, done_cyc, done_cnt, int'(busy), ord_err};
      exp = '{4, 4, 7, 1, 0, 0};
      nm  = '{"wr_cnt", "rd_cnt", "done_cyc", "done_cnt", "busy_c8", "addr_order"};
      for (int k = 0; k < 6; k++) begin
         nvec++;
         if (got[k] !== exp[k]) begin
            nmis++;
            $display("FAIL ignore.%s: got %0d want %0d", nm[k], got[k], exp[k]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (res[k] !== ev[k]) begin
            nmis++;
            $display("FAIL ignore.data[%0d]: got %0d want %0d", k, res[k], ev[k]);
         end
      end
      // second run, p = 3000, launched from the first IDLE cycle
      mem_a[0] = 12'd2999; mem_a[1] = 12'd5;
      mem_b[0] = 12'd1;    mem_b[1] = 12'd6;
      launch(2, 1096);
      wait_done(40);
      got = '{wr_cnt, rd_cnt, done_cyc, done_cnt, 32'(res[0]), 32'(res[1])};
      exp = '{2, 2, 5, 1, 0, 11};
      nm  = '{"wr_cnt", "rd_cnt", "done_cyc", "done_cnt", "data0", "data1"};
      for (int k = 0; k < 6; k++) begin
         nvec++;
         if (got[k] !== exp[k]) begin
            nmis++;
            $display("FAIL second.%s: got %0d want %0d", nm[k], got[k], exp[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int    got [3];
      int    exp [3];
      string nm  [3];
      for (int i = 0; i < 8; i++) begin
         mem_a[i] = DW'(i * 100);
         mem_b[i] = DW'(i);
      end
      @(negedge clk);
      launch(8, 767);
      repeat (3) @(negedge clk);          // cycle 3
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);                     // cycle 4
      nvec++;
      if (busy !== 1'b0) begin nmis++; $display("FAIL abort.busy_c4: got %b want 0", busy); end
      nvec++;
      if (done !== 1'b0) begin nmis++; $display("FAIL abort.done_c4: got %b want 0", done); end
      nvec++;
      if (bus.wr_en !== 1'b0) begin nmis++; $display("FAIL abort.wr_en_c4: got %b want 0", bus.wr_en); end
      repeat (12) @(negedge clk);
      // reads at cycles 1..3, only index 0 written (cycle 3) before the reset
      got = '{wr_cnt, rd_cnt, done_cnt};
      exp = '{1, 3, 0};
      nm  = '{"wr_cnt", "rd_cnt", "done_cnt"};
      for (int k = 0; k < 3; k++) begin
         nvec++;
         if (got[k] !== exp[k]) begin
            nmis++;
            $display("FAIL abort.%s: got %0d want %0d", nm[k], got[k], exp[k]);
         end
      end
   endtask

   task automatic test_random();
      int n;
      int e;
      for (int it = 0; it < 3; it++) begin
         n = int'($urandom_range(60, 1));
         for (int i = 0; i < n; i++) begin
            mem_a[i] = DW'($urandom_range(3328, 0));
            mem_b[i] = DW'($urandom_range(3328, 0));
         end
         @(negedge clk);
         launch(n, 767);
         wait_done(100);
         nvec++;
         if (wr_cnt !== n) begin
            nmis++;
            $display("FAIL rand%0d.wr_cnt: got %0d want %0d", it, wr_cnt, n);
         end
         nvec++;
         if (done_cyc !== n + 3) begin
            nmis++;
            $display("FAIL rand%0d.done_cyc: got %0d want %0d", it, done_cyc, n + 3);
         end
         for (int i = 0; i < n; i++) begin
            e = (int'(mem_a[i]) + int'(mem_b[i])) % 3329;
            nvec++;
            if (res[i] !== DW'(e)) begin
               nmis++;
               $display("FAIL rand%0d.data[%0d]: got %0d want %0d", it, i, res[i], e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic("basic");
      test_len0();
      test_full();
      test_ignored_start();
      test_reset_mid();
      test_basic("after_abort");
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
